// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one registered 8-bit ALU between NUM_REQ
// requesters, one operation in flight, result returned tagged with the requester id.
`timescale 1ns/1ps

package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } opcode_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ALU_LATENCY = 1,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  input  opcode_t                req_op [NUM_REQ],
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [7:0]             rsp_data,
  output logic                   rsp_zero,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output opcode_t                alu_opcode,
  input  logic [7:0]             alu_out,
  input  logic                   alu_zero,
  output logic [1:0]             state_dbg
);

  localparam int CW = $clog2(ALU_LATENCY + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           cnt_done;

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; req_ready is only offered in IDLE, rsp_valid is high exactly in RESP.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!grant_found && req_valid[IDW'(idx)]) begin
        grant       = IDW'(idx);
        grant_found = 1'b1;
      end
    end
  end

  assign accept    = (state == S_IDLE) && grant_found;
  assign cnt_done  = (cnt == CW'(ALU_LATENCY));
  assign rsp_valid = (state == S_RESP);
  assign state_dbg = state;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_EXEC;
      S_EXEC:  if (cnt_done)  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operands stay on the ALU pins for the whole EXEC window; the result is
  // sampled once the ALU has had ALU_LATENCY edges to produce it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= ADD;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      last_grant <= IDW'(NUM_REQ - 1);
      cnt        <= '0;
    end else begin
      if (accept) begin
        alu_a      <= req_a[{grant, 3'b000} +: 8];
        alu_b      <= req_b[{grant, 3'b000} +: 8];
        alu_opcode <= req_op[grant];
        rsp_id     <= grant;
        last_grant <= grant;
        cnt        <= '0;
      end else if (state == S_EXEC) begin
        cnt <= cnt + 1'b1;
        if (cnt_done) begin
          rsp_data <= alu_out;
          rsp_zero <= alu_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NUM_REQ=2, ALU_LATENCY=1) with a registered ALU model
// and an expected-response queue checked at every response handshake.
`timescale 1ns/1ps

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 10;  // {id, data, zero}

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  opcode_t     req_op [2];
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_zero;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  opcode_t     alu_opcode;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_zero = 1'b0;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rdy0_cnt = 0;
  int acc_cyc[$];
  logic [W-1:0] exp_q[$];

  alu_arbiter #(.NUM_REQ(2), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- registered ALU model ----------------
  function automatic logic [7:0] alu_f(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOT:     return ~a;
      SHL:     return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_out  <= alu_f(alu_opcode, alu_a, alu_b);
    alu_zero <= (alu_f(alu_opcode, alu_a, alu_b) == 8'h00);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [7:0] data, input logic zero);
    exp_q.push_back({id, data, zero});
  endtask

  // Scoreboard: inputs move #1 after posedge, so the negedge sees a settled handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp", 32'({rsp_id, rsp_data, rsp_zero}), 32'(exp_q.pop_front()));
    end
    if (rst_n && req_ready[0]) rdy0_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_accepts(input string tag, input int n, input int budget);
    int got;
    int t;
    got = 0;
    t   = 0;
    while (got < n && t < budget) begin
      #1;
      if (|(req_ready & req_valid)) begin
        got++;
        acc_cyc.push_back(cyc);
      end
      tick();
      t++;
    end
    check(tag, 32'(got), 32'(n));
  endtask

  task automatic drain(input string tag, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int seen;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op[0] = ADD;
    req_op[1] = ADD;
    rsp_ready = 1'b1;
    tick();
    tick();

    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(rsp_id), 32'd0);
    check("rst_rsp_data",  32'(rsp_data), 32'd0);
    check("rst_rsp_zero",  32'(rsp_zero), 32'd0);
    check("rst_alu_a",     32'(alu_a), 32'd0);
    check("rst_alu_b",     32'(alu_b), 32'd0);
    check("rst_alu_op",    32'(alu_opcode), 32'(ADD));
    check("rst_state",     32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single ADD from req0, exact latency
    req_a = 16'h0005; req_b = 16'h0003; req_op[0] = ADD; req_valid = 2'b01;
    #1;
    check("t1_ready", 32'(req_ready), 32'b01);
    push_exp(1'b0, 8'h08, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    check("t1_ready_drop", 32'(req_ready), 32'd0);
    check("t1_alu_a",  32'(alu_a), 32'h05);
    check("t1_alu_b",  32'(alu_b), 32'h03);
    check("t1_alu_op", 32'(alu_opcode), 32'(ADD));
    tick();
    check("t1_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id",    32'(rsp_id), 32'd0);
    check("t1_rsp_data",  32'(rsp_data), 32'h08);
    check("t1_rsp_zero",  32'(rsp_zero), 32'd0);
    tick();
    check("t1_rsp_drop",  32'(rsp_valid), 32'd0);
    drain("t1_drain", 10);

    // 2: both valid after reset -> req0 first, then req1
    apply_reset();
    req_a = 16'h0505; req_b = 16'h0305;
    req_op[0] = SUB; req_op[1] = XOR;
    req_valid = 2'b11;
    #1;
    check("t2_ready_first", 32'(req_ready), 32'b01);
    push_exp(1'b0, 8'h00, 1'b1);
    push_exp(1'b1, 8'h06, 1'b0);
    run_accepts("t2_acc0", 1, 10);
    check("t2_alu_op", 32'(alu_opcode), 32'(SUB));
    req_valid = 2'b10;
    run_accepts("t2_acc1", 1, 10);
    req_valid = 2'b00;
    drain("t2_drain", 20);

    // 3: both held for four operations -> ids 0,1,0,1
    req_a = 16'h1001; req_b = 16'h0102;
    req_op[0] = ADD; req_op[1] = SUB;
    req_valid = 2'b11;
    push_exp(1'b0, 8'h03, 1'b0);
    push_exp(1'b1, 8'h0F, 1'b0);
    push_exp(1'b0, 8'h03, 1'b0);
    push_exp(1'b1, 8'h0F, 1'b0);
    run_accepts("t3_acc", 4, 40);
    req_valid = 2'b00;
    drain("t3_drain", 20);

    // 4: consumer stalls 5 cycles in RESP with req1 pending
    rsp_ready = 1'b0;
    req_a = 16'hFF7F; req_b = 16'hFF01;
    req_op[0] = ADD; req_op[1] = XOR;
    req_valid = 2'b01;
    push_exp(1'b0, 8'h80, 1'b0);
    push_exp(1'b1, 8'h00, 1'b1);
    run_accepts("t4_acc0", 1, 10);
    req_valid = 2'b10;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_id",    32'(rsp_id), 32'd0);
      check("t4_hold_data",  32'(rsp_data), 32'h80);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    check("t4_queue_held", 32'(exp_q.size()), 32'd2);
    rsp_ready = 1'b1;
    run_accepts("t4_acc1", 1, 10);
    req_valid = 2'b00;
    drain("t4_drain", 20);

    // 5: reset during EXEC aborts the operation and restores round-robin start
    req_a = 16'h0001; req_b = 16'h0001; req_op[0] = ADD;
    req_valid = 2'b01;
    run_accepts("t5_acc", 1, 10);
    req_valid = 2'b00;
    check("t5_in_exec", 32'(state_dbg), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_alu_a", 32'(alu_a), 32'd0);
    check("t5_rst_state", 32'(state_dbg), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("t5_no_rsp", 32'(seen), 32'd0);
    req_a = 16'h0902; req_b = 16'h0903;
    req_op[0] = ADD; req_op[1] = ADD;
    req_valid = 2'b11;
    #1;
    check("t5_ready_req0", 32'(req_ready), 32'b01);
    push_exp(1'b0, 8'h05, 1'b0);
    push_exp(1'b1, 8'h12, 1'b0);
    run_accepts("t5_acc2", 2, 20);
    req_valid = 2'b00;
    drain("t5_drain", 20);

    // 6: req1 alone, held -> one accept every 4 cycles, req0 never offered
    req_a = 16'h0300; req_b = 16'h0300; req_op[1] = SUB;
    acc_cyc.delete();
    rdy0_cnt = 0;
    req_valid = 2'b10;
    push_exp(1'b1, 8'h00, 1'b1);
    push_exp(1'b1, 8'h00, 1'b1);
    push_exp(1'b1, 8'h00, 1'b1);
    run_accepts("t6_acc", 3, 30);
    req_valid = 2'b00;
    if (acc_cyc.size() == 3) begin
      check("t6_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      check("t6_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    end else begin
      check("t6_acc_log", 32'(acc_cyc.size()), 32'd3);
    end
    drain("t6_drain", 20);
    check("t6_rdy0", 32'(rdy0_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
